// File: rtl/riscv_gpio_arb.sv
// riscv_gpio_arb: round-robin arbiter of NREQ requesters onto one APB-style GPIO register port.
// Define RISCV_GPIO_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins, no direct handoff).
module riscv_gpio_arb #(
  parameter int XLEN = 32,
  parameter int NREQ = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_i,
  input  logic [NREQ-1:0]            write_i,
  input  logic [NREQ-1:0][XLEN-1:0]  addr_i,
  input  logic [NREQ-1:0][XLEN-1:0]  wdata_i,
  output logic [NREQ-1:0]            done_o,
  output logic [XLEN-1:0]            rdata_o,
  output logic [$clog2(NREQ)-1:0]    gnt_id_o,
  output logic                       busy_o,
  output logic                       sel,
  output logic                       enable,
  output logic                       write,
  output logic [XLEN-1:0]            addr,
  output logic [XLEN-1:0]            wdata,
  input  logic [XLEN-1:0]            rdata
);
  localparam int IW = $clog2(NREQ);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] owner_q, owner_d, pick;
  logic write_q, write_d, found, grant;
  logic [XLEN-1:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [NREQ-1:0] cand;
  // the finishing owner is masked out so it must pass through IDLE before winning again
  assign cand = (state_q == ACCESS) ? req_i & ~(NREQ'(1) << owner_q) : req_i;
`ifdef RISCV_GPIO_ARB_FIXED_PRIO_EN
  assign grant = found && state_q == IDLE;
  always_comb begin
    found = 1'b0;
    pick = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (cand[k]) begin
        found = 1'b1;
        pick = IW'(k);
      end
    end
  end
`else
  logic [IW-1:0] last_q;
  assign grant = found && (state_q == IDLE || state_q == ACCESS);
  always_comb begin
    found = 1'b0;
    pick = '0;
    for (int k = NREQ; k >= 1; k--) begin
      if (cand[(int'(last_q) + k) % NREQ]) begin
        found = 1'b1;
        pick = IW'((int'(last_q) + k) % NREQ);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) last_q <= IW'(NREQ - 1);
    else if (grant) last_q <= pick;
  end
`endif
  always_comb begin
    state_d = state_q == SETUP ? ACCESS : grant ? SETUP : state_q == ACCESS ? IDLE : state_q;
    owner_d = grant ? pick : owner_q;
    write_d = grant ? write_i[pick] : write_q;
    addr_d = grant ? addr_i[pick] : addr_q;
    wdata_d = grant ? wdata_i[pick] : wdata_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      write_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      write_q <= write_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
    end
  end
  assign sel = state_q != IDLE;
  assign enable = state_q == ACCESS;
  assign write = sel & write_q;
  assign addr = addr_q;
  assign wdata = wdata_q;
  assign busy_o = sel;
  assign gnt_id_o = owner_q;
  assign done_o = enable ? NREQ'(1) << owner_q : '0;
  assign rdata_o = enable ? rdata : '0;
endmodule

// File: tb/tb_riscv_gpio_arb.sv
// tb_riscv_gpio_arb: scoreboard bench for riscv_gpio_arb, expected completions queued at stimulus time.
module tb_riscv_gpio_arb;
  logic clk = 0, rst = 1;
  logic [1:0] req_i, write_i, done_o;
  logic [1:0][31:0] addr_i, wdata_i;
  logic [31:0] rdata_o, addr, wdata, rdata;
  logic [0:0] gnt_id_o;
  logic busy_o, sel, enable, write;
  riscv_gpio_arb #(.XLEN(32), .NREQ(2)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .write_i(write_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .done_o(done_o), .rdata_o(rdata_o), .gnt_id_o(gnt_id_o),
    .busy_o(busy_o), .sel(sel), .enable(enable), .write(write), .addr(addr),
    .wdata(wdata), .rdata(rdata)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct {
    int cyc;
    logic [1:0] done;
    logic [31:0] rd;
    logic wr;
    logic [31:0] ad;
    logic [31:0] wd;
  } exp_t;
  exp_t sb[$];
  exp_t e;
  int n_err = 0, n_chk = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  task automatic push(input int c, input logic [1:0] d, input logic [31:0] rd, input logic wr,
                      input logic [31:0] ad, input logic [31:0] wd);
    exp_t x;
    x.cyc = c; x.done = d; x.rd = rd; x.wr = wr; x.ad = ad; x.wd = wd;
    sb.push_back(x);
  endtask
  always @(negedge clk) begin
    if (!rst && done_o != 2'b00) begin
      if (sb.size() == 0) chk("spurious_done", 32'(done_o), 32'h0);
      else begin
        e = sb.pop_front();
        chk("done_cycle", cyc, e.cyc);
        chk("done_o", 32'(done_o), 32'(e.done));
        chk("rdata_o", rdata_o, e.rd);
        chk("write", 32'(write), 32'(e.wr));
        chk("addr", addr, e.ad);
        chk("wdata", wdata, e.wd);
      end
    end
  end
  int s;
  initial begin
    req_i = 0; write_i = 0; addr_i = '0; wdata_i = '0; rdata = 0;
    repeat (2) @(negedge clk);
    chk("rst_sel", 32'(sel), 0); chk("rst_en", 32'(enable), 0); chk("rst_write", 32'(write), 0);
    chk("rst_addr", addr, 0); chk("rst_wdata", wdata, 0); chk("rst_done", 32'(done_o), 0);
    chk("rst_busy", 32'(busy_o), 0); chk("rst_gnt", 32'(gnt_id_o), 0);
    rst = 0;
    // single write from m0
    s = cyc;
    push(s + 2, 2'b01, 0, 1'b1, 32'h0, 32'hA5);
    req_i = 2'b01; write_i = 2'b01; addr_i[0] = 32'h0; wdata_i[0] = 32'hA5;
    @(negedge clk);
    chk("w_setup_sel", 32'(sel), 1); chk("w_setup_en", 32'(enable), 0);
    chk("w_setup_busy", 32'(busy_o), 1); chk("w_setup_gnt", 32'(gnt_id_o), 0);
    @(negedge clk);
    chk("w_access_en", 32'(enable), 1);
    req_i = 0;
    @(negedge clk);
    chk("w_idle_sel", 32'(sel), 0); chk("w_idle_busy", 32'(busy_o), 0);
    chk("w_idle_write", 32'(write), 0); chk("w_idle_wdata_hold", wdata, 32'hA5);
    // read from m1
    rdata = 32'h1234_5678;
    chk("rdata_o_idle", rdata_o, 0);
    s = cyc;
    push(s + 2, 2'b10, 32'h1234_5678, 1'b0, 32'h10, 32'h77);
    req_i = 2'b10; write_i = 2'b00; addr_i[1] = 32'h10; wdata_i[1] = 32'h77;
    @(negedge clk);
    chk("r_setup_write", 32'(write), 0); chk("r_setup_gnt", 32'(gnt_id_o), 1);
    @(negedge clk);
    chk("r_access_write", 32'(write), 0);
    req_i = 0;
    @(negedge clk);
    rdata = 0;
    // contention after reset
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    s = cyc;
    write_i = 2'b11; addr_i[0] = 32'h4; addr_i[1] = 32'h8; wdata_i[0] = 32'h11; wdata_i[1] = 32'h22;
`ifdef RISCV_GPIO_ARB_FIXED_PRIO_EN
    for (int i = 0; i < 3; i++) push(s + 2 + 3 * i, 2'b01, 0, 1'b1, 32'h4, 32'h11);
`else
    for (int i = 0; i < 4; i++)
      push(s + 2 + 2 * i, i[0] ? 2'b10 : 2'b01, 0, 1'b1, i[0] ? 32'h8 : 32'h4, i[0] ? 32'h22 : 32'h11);
`endif
    req_i = 2'b11;
    repeat (3) @(negedge clk);
`ifdef RISCV_GPIO_ARB_FIXED_PRIO_EN
    chk("c_fixed_idle", 32'(busy_o), 0);
`else
    chk("c_handoff_busy", 32'(busy_o), 1); chk("c_handoff_gnt", 32'(gnt_id_o), 1);
`endif
    repeat (5) @(negedge clk);
    req_i = 0;
    @(negedge clk);
    chk("c_end_busy", 32'(busy_o), 0);
    // owner exclusion: m0 alone keeps requesting
    rdata = 32'h55;
    s = cyc;
    write_i = 2'b00; addr_i[0] = 32'h20;
    for (int i = 0; i < 3; i++) push(s + 2 + 3 * i, 2'b01, 32'h55, 1'b0, 32'h20, 32'h11);
    req_i = 2'b01;
    repeat (3) @(negedge clk);
    chk("o_idle1", 32'(busy_o), 0);
    repeat (3) @(negedge clk);
    chk("o_idle2", 32'(busy_o), 0);
    repeat (2) @(negedge clk);
    req_i = 0;
    @(negedge clk);
    rdata = 0;
    // reset during the ACCESS cycle of an m1 write
    req_i = 2'b10; write_i = 2'b10; addr_i[1] = 32'h30; wdata_i[1] = 32'h99;
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1; req_i = 2'b11;
    @(posedge clk); #1;
    rst = 0;
    s = cyc;
    push(s + 2, 2'b01, 0, 1'b0, 32'h20, 32'h11);
    @(negedge clk);
    chk("ra_sel", 32'(sel), 0); chk("ra_en", 32'(enable), 0); chk("ra_done", 32'(done_o), 0);
    chk("ra_busy", 32'(busy_o), 0); chk("ra_addr", addr, 0);
    @(negedge clk);
    chk("ra_regrant_busy", 32'(busy_o), 1); chk("ra_regrant_gnt", 32'(gnt_id_o), 0);
    @(negedge clk);
    req_i = 0;
    repeat (3) @(negedge clk);
    chk("sb_drain", 32'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
